objectbuffer_dbuf: RTL
======================

Name: objectbuffer_dbuf

Overview:
Parametrised successor to the 4-register object buffer. It is an AXI4-Lite slave holding NUM_OBJECTS objects of WORDS_PER_OBJ 32-bit words each, double-buffered. Software writes a shadow bank. A commit request arms a swap, and the next frame_sync pulse copies shadow to the active bank. The active bank drives the fabric-side object outputs consumed by the video/render pipeline.

Parameters:
NUM_OBJECTS, 4, number of objects (1..64)
WORDS_PER_OBJ, 4, 32-bit words per object (1..16, power of two)
C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported
C_S_AXI_ADDR_WIDTH, 10, byte address width; must cover 0x10 + NUM_OBJECTS*WORDS_PER_OBJ*4

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
frame_sync  in  1  single-cycle swap-point pulse, synchronous to ACLK
obj_data  out  NUM_OBJECTS*WORDS_PER_OBJ*32  active bank, flattened; object o, word w at bit [(o*WORDS_PER_OBJ+w)*32 +: 32]
swap_done  out  1  one-cycle pulse on the cycle after the active bank updates
commit_pending  out  1  swap is armed

Behaviour:
- Reset (ARESETN low, asynchronous): both banks, CTRL, swap_count, all READY/VALID, BRESP/RRESP, RDATA, swap_done and commit_pending are 0. Reset mid-transaction drops the transaction; no response is issued.
- Address map (byte offsets, word aligned, addr[1:0] ignored):
  - 0x00 CTRL. Bit0 COMMIT: writing 1 sets pending; it reads back as pending. Bit1 FORCE: writing 1 swaps on the next cycle without waiting for sync; it is self-clearing and reads 0.
  - 0x04 STATUS, read-only. Bit0 = pending; [31:16] = swap_count, which wraps at 0xFFFF to 0.
  - 0x08, 0x0C: reserved. Reads return 0 with OKAY; writes are ignored with OKAY.
  - 0x10 + (o*WORDS_PER_OBJ + w)*4: shadow word, read/write.
  - Any address beyond the last shadow word: SLVERR. Reads of such addresses return RDATA=0; writes are dropped.
- Write path: one outstanding write at a time.
  - AWREADY and WREADY assert together for one cycle when AWVALID and WVALID are both high and BVALID is low.
  - The register updates on that cycle, honouring WSTRB per byte.
  - BVALID asserts the next cycle and holds until BREADY.
  - Latency from AW/W accept to BVALID is 1 cycle.
- Read path: one outstanding read at a time.
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RDATA/RRESP are captured in that cycle; RVALID asserts the next cycle and holds until RREADY. Latency is 1 cycle.
  - Reads of object words return the shadow bank.
- A read and a write to the same address in the same cycle: the read returns the pre-write value.
- Swap:
  - When pending is set and frame_sync=1, the active bank takes the shadow bank at the clock edge, pending clears, and swap_count increments. swap_done pulses on the following cycle.
  - frame_sync with pending=0: no effect.
  - A COMMIT write in the same cycle as frame_sync: pending is set, but the swap waits for the next frame_sync.
  - A shadow write in the same cycle as a swap: the active bank gets the pre-write shadow value; the write lands in shadow only.
  - FORCE behaves as an internal sync pulse, whether or not pending is set. It also clears pending.
- obj_data is a registered output and changes only on a swap.

Decomposition:
- Package objectbuffer_pkg holds:
  - register offset constants (CTRL, STATUS, OBJ_BASE=0x10);
  - RESP_OKAY/RESP_SLVERR;
  - CTRL bit indices;
  - a function mapping a byte address to {valid, object index, word index}.
- One sub-module, objectbuffer_axil_if, contains the AXI4-Lite handshake FSMs. It presents wr_en/wr_addr/wr_data/wr_strb and rd_en/rd_addr/rd_data/rd_err to the core.
- The core holds the banks, CTRL/STATUS logic and swap logic.

Test Plan:
- Write 0x00000001..0x00000010 to 0x10..0x4C (NUM_OBJECTS=4, WORDS_PER_OBJ=4), then read back -> all 16 values match with OKAY; obj_data stays 0.
- Write CTRL=0x1, then pulse frame_sync -> one cycle later swap_done=1, obj_data word0=0x1 and word15=0x10; STATUS reads 0x00010000.
- Write 0xAABBCCDD with WSTRB=0b0101 to 0x10, which holds 0x11223344 -> reads back 0x11BB33DD.
- Read 0x50 and write 0x50 -> RRESP=BRESP=2'b10, RDATA=0, no register changes.
- Write COMMIT in the same cycle as frame_sync -> no swap; the next frame_sync swaps; swap_count=1.
- Drop ARESETN during a held BVALID with BREADY=0 -> BVALID=0 immediately and all registers cleared; after release, the next write completes normally.

Source files
------------

// File: rtl/objectbuffer_dbuf_pkg.sv
// Shared constants, FSM state types and address decode for the double-buffered object buffer.
package objectbuffer_pkg;

  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_RSVD0  = 32'h0000_0008;
  localparam logic [31:0] REG_RSVD1  = 32'h0000_000C;
  localparam logic [31:0] OBJ_BASE   = 32'h0000_0010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_FORCE_BIT  = 1;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_RESP   = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic       valid;
    logic [5:0] obj;
    logic [3:0] word;
  } obj_loc_t;

  // Maps a byte address onto an (object, word) slot of the shadow bank; low two bits are ignored.
  function automatic obj_loc_t obj_decode(input logic [31:0] byte_addr,
                                          input int unsigned num_obj,
                                          input int unsigned wpo);
    obj_loc_t    loc;
    logic [31:0] off;
    loc = '0;
    off = (byte_addr - OBJ_BASE) >> 2;
    if ((byte_addr >= OBJ_BASE) && (off < num_obj * wpo)) begin
      loc.valid = 1'b1;
      loc.obj   = 6'(off / wpo);
      loc.word  = 4'(off % wpo);
    end else begin
      loc = '0;
    end
    return loc;
  endfunction

endpackage

// File: rtl/objectbuffer_dbuf_if.sv
// AXI4-Lite bus bundle; slave modport faces the object buffer, master modport faces the driver.
interface objectbuffer_dbuf_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/objectbuffer_dbuf_axil_if.sv
// AXI4-Lite handshake engine: one outstanding write and one outstanding read, 1-cycle response latency.
module objectbuffer_axil_if
  import objectbuffer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  objectbuffer_dbuf_if.slave s_axi,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_strb_o,
  input  logic              wr_err_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_i,
  input  logic              rd_err_i
);

  wr_state_e   wr_state_q;
  rd_state_e   rd_state_q;
  logic        awready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  // The core commits a write (or samples read data) in the cycle the READY pulse is high.
  assign wr_en_o   = (wr_state_q == WR_ACCEPT);
  assign wr_addr_o = s_axi.AWADDR;
  assign wr_data_o = s_axi.WDATA;
  assign wr_strb_o = s_axi.WSTRB;
  assign rd_en_o   = (rd_state_q == RD_ACCEPT);
  assign rd_addr_o = s_axi.ARADDR;

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = awready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;

  // Write channel FSM: joint AW/W acceptance, then B held until BREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (s_axi.AWVALID && s_axi.WVALID) begin
            awready_q  <= 1'b1;
            wr_state_q <= WR_ACCEPT;
          end
        end
        WR_ACCEPT: begin
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b1;
          bresp_q    <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
          wr_state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi.BREADY) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          awready_q  <= 1'b0;
          bvalid_q   <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: ARREADY pulse captures data/response, R held until RREADY.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= 32'h0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (s_axi.ARVALID) begin
            arready_q  <= 1'b1;
            rd_state_q <= RD_ACCEPT;
          end
        end
        RD_ACCEPT: begin
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b1;
          rdata_q    <= rd_data_i;
          rresp_q    <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
          rd_state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axi.RREADY) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/objectbuffer_dbuf.sv
// Double-buffered object register file: software fills shadow, a commit plus frame_sync (or FORCE) copies it to active.
module objectbuffer_dbuf
  import objectbuffer_pkg::*;
#(
  parameter int NUM_OBJECTS        = 4,
  parameter int WORDS_PER_OBJ      = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                                      ACLK,
  input  logic                                      ARESETN,
  objectbuffer_dbuf_if.slave                        s_axi,
  input  logic                                      frame_sync,
  output logic [NUM_OBJECTS*WORDS_PER_OBJ*32-1:0]   obj_data,
  output logic                                      swap_done,
  output logic                                      commit_pending
);

  localparam int NW = NUM_OBJECTS * WORDS_PER_OBJ;
  localparam int BW = NW * 32;

  logic                          wr_en_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_s;
  logic [31:0]                   wr_data_s;
  logic [3:0]                    wr_strb_s;
  logic                          wr_err_s;
  logic                          rd_en_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr_s;
  logic [31:0]                   rd_data_s;
  logic                          rd_err_s;

  logic [31:0] wa_s, ra_s, wword_s, rword_s;
  obj_loc_t    wloc_s, rloc_s;
  int          widx_s, ridx_s;
  logic        wr_ctrl_s, swap_s;

  logic [BW-1:0] shadow_q, shadow_d, active_q;
  logic          pending_q, pending_d;
  logic          force_q, force_d;
  logic [15:0]   count_q, count_d;
  logic          swap_done_q;

  objectbuffer_axil_if #(.ADDR_W(C_S_AXI_ADDR_WIDTH)) u_axil (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .s_axi     (s_axi),
    .wr_en_o   (wr_en_s),
    .wr_addr_o (wr_addr_s),
    .wr_data_o (wr_data_s),
    .wr_strb_o (wr_strb_s),
    .wr_err_i  (wr_err_s),
    .rd_en_o   (rd_en_s),
    .rd_addr_o (rd_addr_s),
    .rd_data_i (rd_data_s),
    .rd_err_i  (rd_err_s)
  );

  assign wa_s    = 32'(wr_addr_s);
  assign ra_s    = 32'(rd_addr_s);
  assign wword_s = {wa_s[31:2], 2'b00};
  assign rword_s = {ra_s[31:2], 2'b00};
  assign wloc_s  = obj_decode(wa_s, NUM_OBJECTS, WORDS_PER_OBJ);
  assign rloc_s  = obj_decode(ra_s, NUM_OBJECTS, WORDS_PER_OBJ);
  assign widx_s  = int'(wloc_s.obj) * WORDS_PER_OBJ + int'(wloc_s.word);
  assign ridx_s  = int'(rloc_s.obj) * WORDS_PER_OBJ + int'(rloc_s.word);

  assign wr_err_s  = !((wword_s == REG_CTRL) || (wword_s == REG_STATUS) ||
                       (wword_s == REG_RSVD0) || (wword_s == REG_RSVD1) || wloc_s.valid);
  assign wr_ctrl_s = wr_en_s && (wword_s == REG_CTRL) && wr_strb_s[0];
  // pending_q is the pre-write value, so a COMMIT landing with frame_sync only arms the next sync.
  assign swap_s    = (pending_q && frame_sync) || force_q;

  assign obj_data       = active_q;
  assign swap_done      = swap_done_q;
  assign commit_pending = pending_q;

  // Read mux: sampled by the handshake engine in the ARREADY cycle, before any same-cycle write lands.
  always_comb begin
    rd_data_s = 32'h0;
    rd_err_s  = 1'b0;
    if (rd_en_s) begin
      if (rword_s == REG_CTRL) begin
        rd_data_s = {31'h0, pending_q};
      end else if (rword_s == REG_STATUS) begin
        rd_data_s = {count_q, 15'h0, pending_q};
      end else if ((rword_s == REG_RSVD0) || (rword_s == REG_RSVD1)) begin
        rd_data_s = 32'h0;
      end else if (rloc_s.valid) begin
        rd_data_s = shadow_q[ridx_s*32 +: 32];
      end else begin
        rd_err_s = 1'b1;
      end
    end else begin
      rd_data_s = 32'h0;
      rd_err_s  = 1'b0;
    end
  end

  // Next-state for the shadow bank and the commit/force/swap-count control.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    force_d   = 1'b0;
    count_d   = count_q;
    if (wr_en_s && wloc_s.valid) begin
      for (int b = 0; b < 4; b++) begin
        shadow_d[widx_s*32 + b*8 +: 8] = wr_strb_s[b] ? wr_data_s[b*8 +: 8]
                                                      : shadow_q[widx_s*32 + b*8 +: 8];
      end
    end else begin
      shadow_d = shadow_q;
    end
    if (wr_ctrl_s && wr_data_s[CTRL_COMMIT_BIT]) begin
      pending_d = 1'b1;
    end else if (swap_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    force_d = wr_ctrl_s && wr_data_s[CTRL_FORCE_BIT];
    count_d = swap_s ? count_q + 16'd1 : count_q;
  end

  // State registers; the active bank copies the pre-write shadow contents on a swap.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      force_q     <= 1'b0;
      count_q     <= 16'h0;
      swap_done_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= swap_s ? shadow_q : active_q;
      pending_q   <= pending_d;
      force_q     <= force_d;
      count_q     <= count_d;
      swap_done_q <= swap_s;
    end
  end

endmodule
